// File: rtl/add_num_pkg.sv
// Shared types and constants for the add-num summing stage.
// Lane geometry, operand-pair and result-entry bundles.
package add_num_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 64;
    localparam int OP_MAX = 32;
    localparam int SUM_W  = OP_MAX + 1;

    // One lane's operand pair, sized for the widest legal W.
    typedef struct packed {
        logic [OP_MAX-1:0] b;
        logic [OP_MAX-1:0] a;
    } op_pair_t;

    // One queued result line: eight sums plus their carry/clamp flags.
    typedef struct packed {
        logic [LANES-1:0][SUM_W-1:0] sum;
        logic [LANES-1:0]            carry;
    } res_entry_t;

    // Mask of the low w bits, held in a sum-wide vector.
    function automatic logic [SUM_W-1:0] op_mask(input int w);
        return (SUM_W'(1) << w) - SUM_W'(1);
    endfunction

endpackage

// File: rtl/add_num_res_fifo.sv
// Result FIFO for the add-num summing stage.
// Registered storage, no bypass; a pop frees a slot for a same-cycle push.
module add_num_res_fifo
    import add_num_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/add_num_sum_stage.sv
// Two-stage eight-lane adder feeding a result FIFO.
// Define ADD_NUM_SUM_SAT_EN to clamp sums at 2^W-1 instead of wrapping.
module add_num_sum_stage
    import add_num_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rsp_valid,
    input  logic [LANES*LANE_W-1:0]   rsp_data,
    output logic                      rsp_alm_full,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [LANES*LANE_W-1:0]   res_data,
    output logic [LANES-1:0]          res_carry,
    output logic                      drop_err,
    output logic [31:0]               line_cnt
);

    localparam logic [SUM_W-1:0]  SUM_MASK = op_mask(W);
    localparam logic [OP_MAX-1:0] OP_MASK  = SUM_MASK[OP_MAX-1:0];
    localparam int                CW       = $clog2(DEPTH) + 2;

    logic                        s1_valid;
    op_pair_t [LANES-1:0]        s1_ops;
    logic [LANES-1:0][SUM_W-1:0] sum_next;
    logic [LANES-1:0]            carry_next;
    res_entry_t                  entry_next;
    logic                        s2_valid;
    res_entry_t                  s2_entry;
    res_entry_t                  head;
    logic [$bits(res_entry_t)-1:0] head_bits;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [$clog2(DEPTH):0]      fifo_count;
    logic                        pop;
    logic [CW-1:0]               pending;
    logic                        unused_bits;

    // Upper lane bits are don't-care by design.
    assign unused_bits = ^rsp_data;

    // Stage 1: capture masked operand pairs; only the valid is reset.
    always_ff @(posedge clk) begin
        if (!reset_n) s1_valid <= 1'b0;
        else          s1_valid <= rsp_valid;
        for (int i = 0; i < LANES; i++) begin
            s1_ops[i].a <= rsp_data[LANE_W*i +: OP_MAX] & OP_MASK;
            s1_ops[i].b <= rsp_data[LANE_W*i+OP_MAX +: OP_MAX] & OP_MASK;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [SUM_W-1:0] raw;
        assign raw = {1'b0, s1_ops[g].a} + {1'b0, s1_ops[g].b};
`ifdef ADD_NUM_SUM_SAT_EN
        assign sum_next[g]   = raw[W] ? SUM_MASK : raw;
        assign carry_next[g] = raw[W];
`else
        assign sum_next[g]   = raw;
        assign carry_next[g] = raw[W];
`endif
    end

    assign entry_next.sum   = sum_next;
    assign entry_next.carry = carry_next;

    // Stage 2: register the sums; this register feeds the FIFO write port.
    always_ff @(posedge clk) begin
        if (!reset_n) s2_valid <= 1'b0;
        else          s2_valid <= s1_valid;
        s2_entry <= entry_next;
    end

    assign pop = res_valid && res_ready;

    add_num_res_fifo #(
        .WIDTH ($bits(res_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s2_valid),
        .push_data (s2_entry),
        .pop       (pop),
        .pop_data  (head_bits),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign head      = head_bits;
    assign res_valid = !fifo_empty;
    assign res_carry = head.carry;

    // Zero-extend each W+1-bit sum into its 64-bit result lane.
    always_comb begin
        res_data = '0;
        for (int i = 0; i < LANES; i++) begin
            res_data[LANE_W*i +: LANE_W] = {{(LANE_W-SUM_W){1'b0}}, head.sum[i]};
        end
    end

    assign pending = CW'(fifo_count) + CW'(s1_valid) + CW'(s2_valid);

    // Almost-full counts queued lines plus both in-flight stages.
    always_ff @(posedge clk) begin
        if (!reset_n) rsp_alm_full <= 1'b0;
        else          rsp_alm_full <= (pending >= CW'(DEPTH - 1));
    end

    // Sticky overflow flag: a line reached a full FIFO with no pop.
    always_ff @(posedge clk) begin
        if (!reset_n)                             drop_err <= 1'b0;
        else if (s2_valid && fifo_full && !pop)   drop_err <= 1'b1;
    end

    // Count of popped result lines, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!reset_n) line_cnt <= '0;
        else if (pop) line_cnt <= line_cnt + 32'd1;
    end

endmodule

// File: doc/add_num_sum_stage.md
ADD_NUM_SUM_STAGE -- requirements
Module: add_num_sum_stage

Interface
REQ-001 Parameter W, default 32: operand width in bits, legal range 8..32.
REQ-002 Parameter DEPTH, default 4: result FIFO entries, power of two, minimum 4.
REQ-003 clk  in  1: sole clock, the CCI-P host clock.
REQ-004 reset_n  in  1: synchronous, active-low reset.
REQ-005 rsp_valid  in  1: c0 memory read response valid; cannot be back-pressured.
REQ-006 rsp_data  in  512: response line; 8 lanes of 64 bits, lane i = bits [64i+63:64i].
REQ-007 rsp_alm_full  out  1: read requester SHALL NOT issue a new read while high.
REQ-008 res_valid  out  1: result line available.
REQ-009 res_ready  in  1: write stage accepts result (write data and header issued this cycle).
REQ-010 res_data  out  512: result line; lane i holds sum i, zero-extended to 64 bits.
REQ-011 res_carry  out  8: per-lane carry-out (saturation flag when SAT compiled in).
REQ-012 drop_err  out  1: sticky; a response arrived with no FIFO space.
REQ-013 line_cnt  out  32: count of result lines popped.

Function
REQ-014 Operands: lane i a = lane[W-1:0], b = lane[32+W-1:32]; upper lane bits SHALL be ignored.
REQ-015 Stage 1 (cycle N+1 after rsp_valid at N): register the 16 operands and a valid bit.
REQ-016 Stage 2 (N+2): compute 8 sums of W+1 bits; write {sum, carry} into the FIFO.
REQ-017 res_valid SHALL be high from N+3 at the earliest, i.e. FIFO is registered-output, no bypass.
REQ-018 Pop occurs when res_valid && res_ready; res_data/res_carry SHALL be stable while res_valid && !res_ready.
REQ-019 Simultaneous push and pop with FIFO full SHALL succeed (pop frees the slot in the same cycle).
REQ-020 rsp_alm_full = (count + in-flight stage1/stage2 valids) >= DEPTH-1, registered.
REQ-021 Push when FIFO full and no pop: line discarded, drop_err set and held until reset; count unchanged.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-023 line_cnt SHALL wrap from 2^32-1 to 0.
REQ-024 Sum bits above W+1 in each 64-bit result lane SHALL be zero.

Reset
REQ-025 On reset_n low at a clk edge: stage valids 0, FIFO empty, res_valid 0, rsp_alm_full 0, drop_err 0, line_cnt 0.
REQ-026 Reset mid-operation SHALL discard in-flight and queued lines; data registers need no reset.
REQ-027 rsp_valid during reset SHALL be ignored.

Configuration
REQ-028 Macro ADD_NUM_SUM_SAT_EN defined: each sum clamps to 2^W-1 on overflow, res_carry[i] flags clamping, bit W of the lane is 0.
REQ-029 Macro undefined: sum is W+1-bit modular, res_carry[i] = bit W of the sum.

Structure
REQ-030 Shared package add_num_pkg SHALL hold the lane count (8), lane width (64), the operand-pair typedef and the result-entry typedef.
REQ-031 The FIFO SHALL be a sub-module add_num_res_fifo (parameterised width/depth, count output).
REQ-032 No other sub-modules; the adder lanes are a generate loop.

Verification
REQ-033 Lane 0 a=5,b=7, W=32: one rsp_valid, res_ready=1 -> res_valid at N+3, lane0=12, res_carry=0, line_cnt 1.
REQ-034 All lanes a=b=0xFFFFFFFF: non-SAT -> each lane 0x1_FFFFFFFE, res_carry=0xFF; SAT -> 0xFFFFFFFF, res_carry=0xFF.
REQ-035 res_ready=0, DEPTH=4, back-to-back responses -> rsp_alm_full high once 3 lines queued or in flight; 5th line with FIFO full sets drop_err, FIFO holds first 4 intact.
REQ-036 FIFO full, push and pop in same cycle -> no drop, count stays 4, order preserved over 10 lines.
REQ-037 Reset asserted with 2 lines queued and 1 in stage 2 -> next cycle res_valid=0, line_cnt=0, subsequent line emerges alone at N+3.
REQ-038 Upper lane garbage (bits 63:32+W, 31:W set to 1) with W=8, a=200, b=100 -> lane = 300, upper bits zero.
